// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and constants for the UART transmit feeder.
// Build option: UART_TX_CHKSUM_EN appends an XOR checksum byte after each packet.
package uart_tx_feeder_pkg;

    // Cycles to wait for tx_busy before re-pulsing the same byte
    localparam int RETRY_CYCLES = 4;
    localparam int RETRY_W      = 3;

`ifdef UART_TX_CHKSUM_EN
    // Entry is {last, byte}
    localparam int FIFO_W = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        CHK       = 2'd3
    } fsm_state_e;
`else
    localparam int FIFO_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } fsm_state_e;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO with a separate occupancy counter so full/empty are
// unambiguous, plus a sticky overflow flag for writes that arrive while full.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_req,
    input  logic [W-1:0]  push_data,
    input  logic          pop_req,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A write while full is dropped even if a pop frees a slot that same cycle
    assign push = push_req && !full;
    assign pop  = pop_req && !empty;

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push_req && full);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system-side bytes and hands them to the UART transmitter one at a
// time, pacing on tx_busy and re-pulsing if the transmitter never responds.
// Build option: UART_TX_CHKSUM_EN closes each packet with an XOR checksum byte.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        overflow,
    input  logic        tx_busy,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data_out
);

    fsm_state_e          state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic                pop;
    logic [FIFO_W-1:0]   fifo_in;
    logic [FIFO_W-1:0]   fifo_out;

`ifdef UART_TX_CHKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic       pend_q, pend_d;
    assign fifo_in = {wr_last, wr_data};
`else
    logic unused_wr_last;
    assign unused_wr_last = wr_last;
    assign fifo_in        = wr_data;
`endif

    assign tx_data_valid = tx_valid_q;
    assign tx_data_out   = tx_data_q;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (wr_en),
        .push_data (fifo_in),
        .pop_req   (pop),
        .pop_data  (fifo_out),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    // Issue FSM: pop and pulse, wait for busy (retrying), wait for idle
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        retry_cnt_d = retry_cnt_q;
        pop         = 1'b0;
`ifdef UART_TX_CHKSUM_EN
        acc_d       = acc_q;
        pend_d      = pend_q;
`endif
        case (state_q)
            IDLE: begin
                // tx_busy gate also covers a transmitter still mid-frame after reset
                if (!empty && !tx_busy) begin
                    pop         = 1'b1;
                    tx_data_d   = fifo_out[7:0];
                    tx_valid_d  = 1'b1;
                    retry_cnt_d = '0;
                    state_d     = WAIT_BUSY;
`ifdef UART_TX_CHKSUM_EN
                    acc_d = acc_q ^ fifo_out[7:0];
                    if (fifo_out[8]) pend_d = 1'b1;
`endif
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (retry_cnt_q == RETRY_W'(RETRY_CYCLES - 1)) begin
                    // Transmitter missed the pulse: resend the held byte, no pop
                    tx_valid_d  = 1'b1;
                    retry_cnt_d = '0;
                end else begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_TX_CHKSUM_EN
                    state_d = pend_q ? CHK : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_TX_CHKSUM_EN
            CHK: begin
                tx_data_d   = acc_q;
                tx_valid_d  = 1'b1;
                acc_d       = '0;
                pend_d      = 1'b0;
                retry_cnt_d = '0;
                state_d     = WAIT_BUSY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

`ifdef UART_TX_CHKSUM_EN
    // Checksum accumulator and pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 8'h00;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder, with a transmitter model
// that raises busy one cycle after each pulse and holds it for 10 cycles.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HOLD  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        full, empty, overflow;
    logic [AW:0] level;
    logic        tx_busy;
    logic        tx_data_valid;
    logic [7:0]  tx_data_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic model_en, manual_busy, ignore_en;
    logic model_busy = 1'b0;
    logic raise = 1'b0;
    logic ignored_once = 1'b0;
    logic prev_valid = 1'b0;
    logic consec = 1'b0;
    int   hold_cnt = 0;
    logic [7:0] sent_q[$];
    int   sent_cyc[$];

    assign tx_busy = model_en ? model_busy : manual_busy;

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow),
        .tx_busy       (tx_busy),
        .tx_data_valid (tx_data_valid),
        .tx_data_out   (tx_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model and pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            raise      = 1'b0;
            hold_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            if (!ignore_en) ignored_once = 1'b0;
            if (raise) begin
                model_busy = 1'b1;
                hold_cnt   = HOLD;
                raise      = 1'b0;
            end else if (model_busy) begin
                hold_cnt = hold_cnt - 1;
                if (hold_cnt == 0) model_busy = 1'b0;
            end
            if (tx_data_valid) begin
                sent_q.push_back(tx_data_out);
                sent_cyc.push_back(cyc);
                if (prev_valid) consec = 1'b1;
                if (model_en) begin
                    if (ignore_en && !ignored_once) ignored_once = 1'b1;
                    else raise = 1'b1;
                end
            end
            prev_valid = tx_data_valid;
        end
    end

    // Called and returns at a negedge
    task automatic push(input logic [7:0] d, input logic l);
        wr_en = 1'b1; wr_data = d; wr_last = l;
        @(negedge clk);
        wr_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int q = 0;
        for (int i = 0; i < 3000 && q < 8; i++) begin
            @(negedge clk);
            if (!tx_busy && empty && !tx_data_valid) q++; else q = 0;
        end
        checks++;
        if (q < 8) begin errors++; $display("FAIL %s_quiet: got busy/queue activity, expected idle", name); end
    endtask

    task automatic wait_sent(input int base, input int n, input string name);
        for (int i = 0; i < 3000 && (sent_q.size() - base) < n; i++) @(negedge clk);
        checks++;
        if (sent_q.size() - base < n) begin
            errors++; $display("FAIL %s_timeout: got %0d pulses, expected %0d", name, sent_q.size() - base, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", tx_data_valid); end
        if (tx_data_out !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h expected 00", tx_data_out); end
        if (full !== 1'b0)          begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        if (empty !== 1'b1)         begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        if (level !== 5'd0)         begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (overflow !== 1'b0)      begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        model_en = 1'b1;
        push(8'hA5, 1'b0);
        checks += 2;
        if (empty !== 1'b0)         begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", tx_data_valid); end
        @(negedge clk);
        checks += 3;
        if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", tx_data_valid); end
        if (tx_data_out !== 8'hA5)  begin errors++; $display("FAIL single_data: got %h expected a5", tx_data_out); end
        if (empty !== 1'b1)         begin errors++; $display("FAIL single_popped: got %b expected 1", empty); end
        @(negedge clk);
        checks++;
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_fall: got %b expected 0", tx_data_valid); end
        wait_quiet("single");
        checks += 2;
        if (tx_data_out !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h expected a5", tx_data_out); end
        if (level !== 5'd0)        begin errors++; $display("FAIL single_level: got %0d expected 0", level); end
    endtask

    task automatic test_burst();
        int base;
        model_en = 1'b0; manual_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        checks += 3;
        if (full !== 1'b1)     begin errors++; $display("FAIL burst_full: got %b expected 1", full); end
        if (level !== 5'd16)   begin errors++; $display("FAIL burst_level: got %0d expected 16", level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_early: got %b expected 0", overflow); end
        push(8'hFF, 1'b0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf: got %b expected 1", overflow); end
        if (level !== 5'd16)   begin errors++; $display("FAIL burst_level17: got %0d expected 16", level); end
        base = sent_q.size();
        manual_busy = 1'b0; model_en = 1'b1;
        wait_sent(base, 16, "burst");
        wait_quiet("burst");
        repeat (30) @(negedge clk);
        checks++;
        if (sent_q.size() - base !== 16) begin errors++; $display("FAIL burst_count: got %0d expected 16", sent_q.size() - base); end
        for (int i = 0; i < 16 && base + i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[base+i] !== 8'(i)) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, sent_q[base+i], 8'(i)); end
        end
    endtask

    task automatic test_push_pop();
        int base;
        model_en = 1'b0; manual_busy = 1'b1;
        push(8'h21, 1'b0); push(8'h22, 1'b0); push(8'h23, 1'b0);
        checks++;
        if (level !== 5'd3) begin errors++; $display("FAIL pp_pre: got %0d expected 3", level); end
        base = sent_q.size();
        manual_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h24;
        @(negedge clk);
        wr_en = 1'b0;
        checks += 3;
        if (level !== 5'd3)         begin errors++; $display("FAIL pp_level: got %0d expected 3", level); end
        if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL pp_valid: got %b expected 1", tx_data_valid); end
        if (tx_data_out !== 8'h21)  begin errors++; $display("FAIL pp_data: got %h expected 21", tx_data_out); end
        manual_busy = 1'b1;
        @(negedge clk);
        manual_busy = 1'b0; model_en = 1'b1;
        wait_sent(base, 4, "pp");
        wait_quiet("pp");
        for (int i = 0; i < 4 && base + i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[base+i] !== 8'(8'h21 + i)) begin errors++; $display("FAIL pp_byte%0d: got %h expected %h", i, sent_q[base+i], 8'(8'h21 + i)); end
        end
    endtask

    task automatic test_retry();
        int base;
        model_en = 1'b1; ignore_en = 1'b1;
        base = sent_q.size();
        push(8'h5A, 1'b0);
        wait_sent(base, 2, "retry");
        wait_quiet("retry");
        checks += 2;
        if (sent_q.size() - base !== 2) begin errors++; $display("FAIL retry_count: got %0d expected 2", sent_q.size() - base); end
        if (level !== 5'd0)             begin errors++; $display("FAIL retry_level: got %0d expected 0", level); end
        if (sent_q.size() - base >= 2) begin
            checks += 3;
            if (sent_cyc[base+1] - sent_cyc[base] !== 4) begin errors++; $display("FAIL retry_gap: got %0d expected 4", sent_cyc[base+1] - sent_cyc[base]); end
            if (sent_q[base] !== 8'h5A)   begin errors++; $display("FAIL retry_first: got %h expected 5a", sent_q[base]); end
            if (sent_q[base+1] !== 8'h5A) begin errors++; $display("FAIL retry_second: got %h expected 5a", sent_q[base+1]); end
        end
        ignore_en = 1'b0;
    endtask

`ifdef UART_TX_CHKSUM_EN
    task automatic test_chksum();
        int base;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h70;
        model_en = 1'b0; manual_busy = 1'b1;
        push(8'h12, 1'b0); push(8'h34, 1'b0); push(8'h56, 1'b1);
        base = sent_q.size();
        manual_busy = 1'b0; model_en = 1'b1;
        wait_sent(base, 4, "chk");
        wait_quiet("chk");
        checks += 2;
        if (sent_q.size() - base !== 4) begin errors++; $display("FAIL chk_count: got %0d expected 4", sent_q.size() - base); end
        if (dut.acc_q !== 8'h00)        begin errors++; $display("FAIL chk_acc: got %h expected 00", dut.acc_q); end
        for (int i = 0; i < 4 && base + i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[base+i] !== exp_b[i]) begin errors++; $display("FAIL chk_byte%0d: got %h expected %h", i, sent_q[base+i], exp_b[i]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int base;
        model_en = 1'b0; manual_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b0);
        checks++;
        if (level !== 5'd5) begin errors++; $display("FAIL mid_pre: got %0d expected 5", level); end
        rst = 1'b1;
        @(negedge clk);
        checks += 6;
        if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", tx_data_valid); end
        if (tx_data_out !== 8'h00)  begin errors++; $display("FAIL mid_data: got %h expected 00", tx_data_out); end
        if (full !== 1'b0)          begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
        if (empty !== 1'b1)         begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
        if (level !== 5'd0)         begin errors++; $display("FAIL mid_level: got %0d expected 0", level); end
        if (overflow !== 1'b0)      begin errors++; $display("FAIL mid_ovf: got %b expected 0", overflow); end
        rst = 1'b0;
        base = sent_q.size();
        repeat (6) @(negedge clk);
        manual_busy = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (sent_q.size() !== base) begin errors++; $display("FAIL mid_nopulse: got %0d pulses expected 0", sent_q.size() - base); end
        model_en = 1'b1;
        push(8'h3C, 1'b0);
        @(negedge clk);
        checks += 2;
        if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %b expected 1", tx_data_valid); end
        if (tx_data_out !== 8'h3C)  begin errors++; $display("FAIL mid_new_data: got %h expected 3c", tx_data_out); end
        wait_quiet("mid");
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
        model_en = 1'b0; manual_busy = 1'b0; ignore_en = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_push_pop();
        test_retry();
`ifdef UART_TX_CHKSUM_EN
        test_chksum();
`endif
        test_reset_mid();
        checks++;
        if (consec !== 1'b0) begin errors++; $display("FAIL valid_consec: got %b expected 0", consec); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
